// File: rtl/udma_filter_addrgen.sv
// Filter TX address generator: walks a LINEAR / SLIDING / CIRCULAR / 2D element
// pattern and streams one L2 byte address per element over valid/ready.
module udma_filter_addrgen #(
  parameter int L2_AWIDTH_NOAL = 15,
  parameter int TRANS_SIZE     = 15
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      cfg_start_i,
  input  logic                      cfg_clr_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_start_addr_i,
  input  logic [1:0]                cfg_datasize_i,
  input  logic [1:0]                cfg_mode_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len0_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len1_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len2_i,
  output logic [L2_AWIDTH_NOAL-1:0] addr_o,
  output logic [1:0]                datasize_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      eol_o,
  output logic                      last_o,
  output logic                      busy_o,
  output logic                      done_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [TRANS_SIZE-1:0] ONE_T = {{(TRANS_SIZE-1){1'b0}}, 1'b1};

  state_e r_state;
  state_e w_state_nxt;

  logic [L2_AWIDTH_NOAL-1:0] r_addr;
  logic [L2_AWIDTH_NOAL-1:0] r_row_base;
  logic [TRANS_SIZE-1:0]     r_i;
  logic [TRANS_SIZE-1:0]     r_j;
  logic [TRANS_SIZE-1:0]     r_len0;
  logic [TRANS_SIZE-1:0]     r_rows;
  logic [TRANS_SIZE-1:0]     r_len2;
  logic [1:0]                r_mode;
  logic [1:0]                r_ds;
  logic                      r_done;

  logic [L2_AWIDTH_NOAL-1:0] w_bytes;
  logic [L2_AWIDTH_NOAL-1:0] w_row_step;
  logic [L2_AWIDTH_NOAL-1:0] w_next_base;
  logic [TRANS_SIZE-1:0]     w_start_rows;
  logic                      w_zero_job;
  logic                      w_run;
  logic                      w_xfer;
  logic                      w_eol;
  logic                      w_last;

  // Valid/ready: a transfer happens on any clock edge where valid_o & ready_i;
  // while valid_o & ~ready_i the address, eol and last are held unchanged and
  // valid_o only drops after a transfer (or on cfg_clr_i).
  assign w_run  = (r_state == ST_RUN);
  assign w_xfer = w_run & ready_i;
  assign w_eol  = w_run & (r_i == (r_len0 - ONE_T));
  assign w_last = w_eol & (r_j == (r_rows - ONE_T));

  assign w_start_rows = (cfg_mode_i == 2'd0) ? ONE_T : cfg_len1_i;
  assign w_zero_job   = (cfg_len0_i == '0) || (w_start_rows == '0);

  always_comb begin
    w_bytes = '0;
    case (r_ds)
      2'd0:    w_bytes[0] = 1'b1;
      2'd1:    w_bytes[1] = 1'b1;
      default: w_bytes[2] = 1'b1;
    endcase
  end

  // Row base advance: SLIDING shifts one element, 2D jumps by the stride.
  always_comb begin
    w_row_step = '0;
    case (r_mode)
      2'd1:    w_row_step = w_bytes;
      2'd3:    w_row_step = L2_AWIDTH_NOAL'(r_len2);
      default: w_row_step = '0;
    endcase
  end

  assign w_next_base = r_row_base + w_row_step;

  always_comb begin
    w_state_nxt = r_state;
    if (cfg_clr_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (cfg_start_i && !w_zero_job) w_state_nxt = ST_RUN;
        ST_RUN:  if (w_xfer && w_last)           w_state_nxt = ST_IDLE;
        default:                                 w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_addr     <= '0;
      r_row_base <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_len0     <= '0;
      r_rows     <= '0;
      r_len2     <= '0;
      r_mode     <= '0;
      r_ds       <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (cfg_clr_i) begin
        r_done <= 1'b0;
      end else if (r_state == ST_IDLE) begin
        if (cfg_start_i) begin
          r_len0     <= cfg_len0_i;
          r_rows     <= w_start_rows;
          r_len2     <= cfg_len2_i;
          r_mode     <= cfg_mode_i;
          r_ds       <= cfg_datasize_i;
          r_addr     <= cfg_start_addr_i;
          r_row_base <= cfg_start_addr_i;
          r_i        <= '0;
          r_j        <= '0;
          r_done     <= w_zero_job;
        end
      end else if (w_xfer) begin
        if (w_last) begin
          r_done <= 1'b1;
        end else if (w_eol) begin
          r_i        <= '0;
          r_j        <= r_j + ONE_T;
          r_row_base <= w_next_base;
          r_addr     <= w_next_base;
        end else begin
          r_i    <= r_i + ONE_T;
          r_addr <= r_addr + w_bytes;
        end
      end
    end
  end

  assign addr_o     = r_addr;
  assign datasize_o = r_ds;
  assign valid_o    = w_run;
  assign busy_o     = w_run;
  assign eol_o      = w_eol;
  assign last_o     = w_last;
  assign done_o     = r_done;

endmodule

// File: tb/tb_udma_filter_addrgen.sv
// Bench for udma_filter_addrgen: a reference walk of each job fills an expected
// queue, and a negedge monitor pops and compares on every handshake.
module tb_udma_filter_addrgen;

  localparam int AW = 15;
  localparam int TW = 15;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          cfg_start_i = 1'b0;
  logic          cfg_clr_i = 1'b0;
  logic [AW-1:0] cfg_start_addr_i = '0;
  logic [1:0]    cfg_datasize_i = '0;
  logic [1:0]    cfg_mode_i = '0;
  logic [TW-1:0] cfg_len0_i = '0;
  logic [TW-1:0] cfg_len1_i = '0;
  logic [TW-1:0] cfg_len2_i = '0;
  logic [AW-1:0] addr_o;
  logic [1:0]    datasize_o;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic          eol_o;
  logic          last_o;
  logic          busy_o;
  logic          done_o;

  int checks = 0;
  int failures = 0;
  int n_xfer = 0;

  logic [AW+1:0] exp_q[$];

  udma_filter_addrgen #(.L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TW)) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .cfg_start_i      (cfg_start_i),
    .cfg_clr_i        (cfg_clr_i),
    .cfg_start_addr_i (cfg_start_addr_i),
    .cfg_datasize_i   (cfg_datasize_i),
    .cfg_mode_i       (cfg_mode_i),
    .cfg_len0_i       (cfg_len0_i),
    .cfg_len1_i       (cfg_len1_i),
    .cfg_len2_i       (cfg_len2_i),
    .addr_o           (addr_o),
    .datasize_o       (datasize_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .eol_o            (eol_o),
    .last_o           (last_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // scoreboard monitor: hold-stability and in-order address checking
  logic [AW-1:0] p_addr;
  logic          p_eol, p_last, p_hold = 1'b0;

  always @(negedge clk_i) begin
    logic [AW+1:0] e;
    if (!rstn_i) begin
      p_hold = 1'b0;
    end else begin
      if (p_hold) begin
        checks++;
        if (valid_o !== 1'b1 || {addr_o, eol_o, last_o} !== {p_addr, p_eol, p_last}) begin
          failures++;
          $display("FAIL hold_stable got v=%b addr=%h eol=%b last=%b exp v=1 addr=%h eol=%b last=%b",
                   valid_o, addr_o, eol_o, last_o, p_addr, p_eol, p_last);
        end
      end
      if (valid_o === 1'b1 && ready_i === 1'b1) begin
        n_xfer++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected got addr=%h eol=%b last=%b exp no transfer", addr_o, eol_o, last_o);
        end else begin
          e = exp_q.pop_front();
          if ({addr_o, eol_o, last_o} !== e) begin
            failures++;
            $display("FAIL sb_xfer got addr=%h eol=%b last=%b exp addr=%h eol=%b last=%b",
                     addr_o, eol_o, last_o, e[AW+1:2], e[1], e[0]);
          end
        end
      end
      p_hold = (valid_o === 1'b1) && (ready_i === 1'b0);
      p_addr = addr_o;
      p_eol  = eol_o;
      p_last = last_o;
    end
  end

  // reference walk: row base by multiplication, masked to the address width
  task automatic push_job(input int addr, input int ds, input int mode,
                          input int l0, input int l1, input int l2);
    int bytes, rows, base, a;
    logic eol, last;
    bytes = 1 << ((ds > 2) ? 2 : ds);
    rows  = (mode == 0) ? 1 : l1;
    for (int j = 0; j < rows; j++) begin
      for (int i = 0; i < l0; i++) begin
        case (mode)
          1:       base = j * bytes;
          3:       base = j * l2;
          default: base = 0;
        endcase
        a    = (addr + base + i * bytes) & 32'h7FFF;
        eol  = (i == l0 - 1);
        last = eol && (j == rows - 1);
        exp_q.push_back({a[AW-1:0], eol, last});
      end
    end
  endtask

  // driver tasks
  task automatic start_job(input int addr, input int ds, input int mode,
                           input int l0, input int l1, input int l2);
    @(posedge clk_i); #1;
    cfg_start_addr_i = AW'(addr);
    cfg_datasize_i   = 2'(ds);
    cfg_mode_i       = 2'(mode);
    cfg_len0_i       = TW'(l0);
    cfg_len1_i       = TW'(l1);
    cfg_len2_i       = TW'(l2);
    cfg_start_i      = 1'b1;
    @(posedge clk_i); #1;
    cfg_start_i = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input bit toggle,
                                output int cycles, output bit got_done);
    cycles   = 0;
    got_done = 1'b0;
    while (cycles < budget && !got_done) begin
      @(posedge clk_i); #1;
      if (toggle) ready_i = ~ready_i;
      @(negedge clk_i);
      cycles++;
      if (done_o === 1'b1) got_done = 1'b1;
    end
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({addr_o, datasize_o, valid_o, eol_o, last_o, busy_o, done_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got addr=%h ds=%0d v=%b eol=%b last=%b busy=%b done=%b exp all 0",
               addr_o, datasize_o, valid_o, eol_o, last_o, busy_o, done_o);
    end
  endtask

  task automatic test_linear();
    int cyc; bit got;
    ready_i = 1'b1;
    n_xfer  = 0;
    push_job(32'h100, 2, 0, 4, 0, 0);
    start_job(32'h100, 2, 0, 4, 0, 0);
    cfg_start_addr_i = 15'h3000;
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b1 || valid_o !== 1'b1 || datasize_o !== 2'd2) begin
      failures++;
      $display("FAIL lin_first got busy=%b v=%b ds=%0d exp busy=1 v=1 ds=2", busy_o, valid_o, datasize_o);
    end
    run_until_done(50, 1'b0, cyc, got);
    checks++;
    if (!got || cyc != 4 || n_xfer != 4 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL lin_timing got done=%b cycles=%0d xfers=%0d left=%0d exp done=1 cycles=4 xfers=4 left=0",
               got, cyc, n_xfer, exp_q.size());
    end
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL lin_done_state got v=%b busy=%b exp v=0 busy=0", valid_o, busy_o);
    end
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b0) begin
      failures++;
      $display("FAIL lin_done_pulse got done=%b exp 0", done_o);
    end
    exp_q.delete();
  endtask

  task automatic test_sliding();
    int cyc; bit got;
    ready_i = 1'b1;
    n_xfer  = 0;
    push_job(32'h20, 0, 1, 3, 2, 0);
    start_job(32'h20, 0, 1, 3, 2, 0);
    run_until_done(50, 1'b0, cyc, got);
    checks++;
    if (!got || cyc != 6 || n_xfer != 6 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL slide_run got done=%b cycles=%0d xfers=%0d left=%0d exp done=1 cycles=6 xfers=6 left=0",
               got, cyc, n_xfer, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_2d_backpressure();
    int cyc; bit got;
    ready_i = 1'b0;
    n_xfer  = 0;
    push_job(32'h0, 1, 3, 2, 2, 32'h40);
    start_job(32'h0, 1, 3, 2, 2, 32'h40);
    run_until_done(50, 1'b1, cyc, got);
    checks++;
    if (!got || cyc != 8 || n_xfer != 4 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_2d got done=%b cycles=%0d xfers=%0d left=%0d exp done=1 cycles=8 xfers=4 left=0",
               got, cyc, n_xfer, exp_q.size());
    end
    ready_i = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_circular_wrap();
    int cyc; bit got;
    ready_i = 1'b1;
    n_xfer  = 0;
    push_job(32'h7FFC, 2, 2, 2, 2, 0);
    start_job(32'h7FFC, 2, 2, 2, 2, 0);
    run_until_done(50, 1'b0, cyc, got);
    checks++;
    if (!got || n_xfer != 4 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL circ_wrap got done=%b xfers=%0d left=%0d exp done=1 xfers=4 left=0",
               got, n_xfer, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_abort_restart();
    int cyc; bit got; bit saw_done;
    ready_i = 1'b1;
    n_xfer  = 0;
    push_job(32'h200, 2, 0, 8, 0, 0);
    start_job(32'h200, 2, 0, 8, 0, 0);
    @(posedge clk_i); #1;
    cfg_start_addr_i = 15'h600;
    cfg_datasize_i   = 2'd0;
    cfg_len0_i       = 15'd3;
    cfg_start_i      = 1'b1;
    @(posedge clk_i); #1;
    cfg_start_i = 1'b0;
    cfg_clr_i   = 1'b1;
    @(posedge clk_i); #1;
    cfg_clr_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || n_xfer != 3 || datasize_o !== 2'd2) begin
      failures++;
      $display("FAIL abort_state got v=%b busy=%b done=%b xfers=%0d ds=%0d exp v=0 busy=0 done=0 xfers=3 ds=2",
               valid_o, busy_o, done_o, n_xfer, datasize_o);
    end
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      if (done_o !== 1'b0 || valid_o !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL abort_quiet got done/valid activity=1 exp 0");
    end
    exp_q.delete();
    n_xfer = 0;
    push_job(32'h200, 2, 0, 8, 0, 0);
    start_job(32'h200, 2, 0, 8, 0, 0);
    run_until_done(50, 1'b0, cyc, got);
    checks++;
    if (!got || cyc != 8 || n_xfer != 8 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL abort_restart got done=%b cycles=%0d xfers=%0d left=%0d exp done=1 cycles=8 xfers=8 left=0",
               got, cyc, n_xfer, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_zero_length();
    int modes[2] = '{0, 3};
    int l0s[2]   = '{0, 4};
    for (int k = 0; k < 2; k++) begin
      ready_i = 1'b1;
      n_xfer  = 0;
      start_job(32'h40, 1, modes[k], l0s[k], 0, 8);
      @(negedge clk_i);
      checks++;
      if (done_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b0) begin
        failures++;
        $display("FAIL zero_len%0d got done=%b v=%b busy=%b exp done=1 v=0 busy=0", k, done_o, valid_o, busy_o);
      end
      @(negedge clk_i);
      checks++;
      if (done_o !== 1'b0 || valid_o !== 1'b0 || busy_o !== 1'b0 || n_xfer != 0) begin
        failures++;
        $display("FAIL zero_after%0d got done=%b v=%b busy=%b xfers=%0d exp 0 0 0 0",
                 k, done_o, valid_o, busy_o, n_xfer);
      end
    end
  endtask

  task automatic test_random_2d();
    int cyc, l0, l1, l2, ds, addr; bit got;
    for (int r = 0; r < 3; r++) begin
      l0   = $urandom_range(1, 5);
      l1   = $urandom_range(1, 4);
      l2   = $urandom_range(0, 32'h7FFF);
      ds   = $urandom_range(0, 3);
      addr = $urandom_range(0, 32'h7FFF);
      ready_i = 1'b1;
      n_xfer  = 0;
      push_job(addr, ds, 3, l0, l1, l2);
      start_job(addr, ds, 3, l0, l1, l2);
      run_until_done(100, 1'b0, cyc, got);
      checks++;
      if (!got || n_xfer != l0 * l1 || exp_q.size() != 0) begin
        failures++;
        $display("FAIL rand_2d%0d got done=%b xfers=%0d left=%0d exp done=1 xfers=%0d left=0",
                 r, got, n_xfer, exp_q.size(), l0 * l1);
      end
      exp_q.delete();
    end
  endtask

  task automatic test_async_reset();
    ready_i = 1'b1;
    push_job(32'h300, 2, 0, 8, 0, 0);
    start_job(32'h300, 2, 0, 8, 0, 0);
    @(posedge clk_i);
    #2 rstn_i = 1'b0;
    #1;
    checks++;
    if ({addr_o, datasize_o, valid_o, eol_o, last_o, busy_o, done_o} !== '0) begin
      failures++;
      $display("FAIL async_reset got addr=%h ds=%0d v=%b busy=%b done=%b exp all 0",
               addr_o, datasize_o, valid_o, busy_o, done_o);
    end
    exp_q.delete();
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_linear();
    test_sliding();
    test_2d_backpressure();
    test_circular_wrap();
    test_abort_restart();
    test_zero_length();
    test_random_2d();
    test_async_reset();
    repeat (2) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
